// File: rtl/dll_dllp_pkg.sv
// Shared encodings for the DLLP generator: link states, DLLP type bytes,
// SDP framing token, FSM states and the DLLP CRC-16.
package dll_dllp_pkg;

    typedef enum logic [1:0] {
        DL_INACTIVE = 2'b00,
        DL_INIT     = 2'b01,
        DL_ACTIVE   = 2'b10
    } dlcmsm_e;

    typedef enum logic [1:0] {
        ACKNAK_NONE = 2'b00,
        ACKNAK_ACK  = 2'b01,
        ACKNAK_NAK  = 2'b10
    } acknak_req_e;

    typedef enum logic [7:0] {
        DLLP_ACK     = 8'h00,
        DLLP_NAK     = 8'h10,
        DLLP_UFC_P   = 8'h80,
        DLLP_UFC_NP  = 8'h90,
        DLLP_UFC_CPL = 8'hA0
    } dllp_type_e;

    typedef enum logic [1:0] {
        SENT_NONE = 2'b00,
        SENT_ACK  = 2'b01,
        SENT_NAK  = 2'b10,
        SENT_UFC  = 2'b11
    } dllp_sent_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CRC,
        S_SEND
    } state_e;

    localparam logic [7:0]  SDP_BYTE0  = 8'hF0;
    localparam logic [7:0]  SDP_BYTE1  = 8'hAC;
    localparam logic [15:0] CRC16_POLY = 16'h100B;

    // dllp holds byte0 in [7:0] .. byte3 in [31:24]; bit 0 of each byte goes first.
    function automatic logic [15:0] dllp_crc16(input logic [31:0] dllp);
        logic [15:0] c;
        logic [15:0] result;
        logic        fb;
        c = 16'hFFFF;
        for (int unsigned i = 0; i < 32; i++) begin
            fb = c[15] ^ dllp[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
        c = ~c;
        for (int unsigned i = 0; i < 16; i++) begin
            result[i] = c[15 - i];
        end
        return result;
    endfunction

endpackage

// File: rtl/dll_dllp_generator_timer.sv
// UpdateFC refresh timer: counts while the link is active and pulses expire
// on the last cycle of each period.
module dll_fc_refresh_timer #(
    parameter int unsigned FC_UPDATE_CYCLES = 4096,
    parameter int unsigned FC_TIMER_BITS    = 13
) (
    input  logic sclk,
    input  logic srst,
    input  logic active,
    input  logic clear,
    output logic expire
);

    localparam logic [FC_TIMER_BITS-1:0] LAST = FC_TIMER_BITS'(FC_UPDATE_CYCLES - 1);

    logic [FC_TIMER_BITS-1:0] count;

    assign expire = active && (count == LAST);

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            count <= '0;
        end else if (!active || clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + FC_TIMER_BITS'(1);
        end
    end

endmodule

// File: rtl/dll_dllp_generator.sv
// Ack/Nak/UpdateFC DLLP source: tracks pending DLLPs, frames the chosen one
// with SDP and CRC-16, and offers it to the write-path arbiter.
module dll_dllp_generator
    import dll_dllp_pkg::*;
#(
    parameter int unsigned PIPE_DATA_WIDTH  = 256,
    parameter int unsigned FC_UPDATE_CYCLES = 4096,
    parameter int unsigned FC_TIMER_BITS    = 13
) (
    input  logic                                  sclk,
    input  logic                                  srst,
    input  logic [1:0]                            DLCMSM_i,
    input  logic [1:0]                            acknak_req_i,
    input  logic [11:0]                           acknak_seq_num_i,
    input  logic                                  fc_update_req_i,
    input  logic [7:0]                            fc_p_hdr_i,
    input  logic [7:0]                            fc_np_hdr_i,
    input  logic [7:0]                            fc_cpl_hdr_i,
    input  logic [11:0]                           fc_p_data_i,
    input  logic [11:0]                           fc_np_data_i,
    input  logic [11:0]                           fc_cpl_data_i,
    output logic [7:0][PIPE_DATA_WIDTH/8-1:0]     data_DLLP_o,
    output logic                                  DLLP_valid_o,
    input  logic                                  DLLP_ready_i,
    output logic [1:0]                            dllp_sent_o
);

    localparam int unsigned WORD_W = PIPE_DATA_WIDTH / 8;

    state_e      state;
    logic        ack_pend, nak_pend, fcp_pend, fcnp_pend, fccpl_pend;
    logic [11:0] seq;
    dllp_type_e  sel_type;
    logic [7:0]  sel_hdr;
    logic [11:0] sel_data;

    logic        link_up, req_ack, req_nak, fc_set, expire, timer_clear, sel_ufc;
    logic        pick_valid;
    dllp_type_e  pick_type;
    logic [7:0]  pick_hdr;
    logic [11:0] pick_data;
    logic        sel_nak, sel_ack, sel_fcp, sel_fcnp, sel_fccpl;
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] crc;
    logic [7:0][WORD_W-1:0] frame;
    logic [1:0]  sent_code;

    assign link_up = (DLCMSM_i == DL_ACTIVE);
    assign req_ack = link_up && (acknak_req_i == ACKNAK_ACK);
    assign req_nak = link_up && (acknak_req_i == ACKNAK_NAK);
    assign fc_set  = fc_update_req_i || expire;
    assign sel_ufc = (sel_type == DLLP_UFC_P) || (sel_type == DLLP_UFC_NP) ||
                     (sel_type == DLLP_UFC_CPL);
    assign timer_clear = (state == S_SEND) && link_up && DLLP_ready_i && sel_ufc;

    dll_fc_refresh_timer #(
        .FC_UPDATE_CYCLES (FC_UPDATE_CYCLES),
        .FC_TIMER_BITS    (FC_TIMER_BITS)
    ) u_timer (
        .sclk   (sclk),
        .srst   (srst),
        .active (link_up),
        .clear  (timer_clear),
        .expire (expire)
    );

    // Priority pick; credits are captured from the inputs at this point.
    always_comb begin
        pick_valid = 1'b0;
        pick_type  = DLLP_ACK;
        pick_hdr   = '0;
        pick_data  = seq;
        if (state == S_IDLE && link_up) begin
            pick_valid = 1'b1;
            if (nak_pend) begin
                pick_type = DLLP_NAK;
            end else if (ack_pend) begin
                pick_type = DLLP_ACK;
            end else if (fcp_pend) begin
                pick_type = DLLP_UFC_P;
                pick_hdr  = fc_p_hdr_i;
                pick_data = fc_p_data_i;
            end else if (fcnp_pend) begin
                pick_type = DLLP_UFC_NP;
                pick_hdr  = fc_np_hdr_i;
                pick_data = fc_np_data_i;
            end else if (fccpl_pend) begin
                pick_type = DLLP_UFC_CPL;
                pick_hdr  = fc_cpl_hdr_i;
                pick_data = fc_cpl_data_i;
            end else begin
                pick_valid = 1'b0;
            end
        end
    end

    assign sel_nak   = pick_valid && (pick_type == DLLP_NAK);
    assign sel_ack   = pick_valid && (pick_type == DLLP_ACK);
    assign sel_fcp   = pick_valid && (pick_type == DLLP_UFC_P);
    assign sel_fcnp  = pick_valid && (pick_type == DLLP_UFC_NP);
    assign sel_fccpl = pick_valid && (pick_type == DLLP_UFC_CPL);

    // Ack/Nak carry hdr=0 and seq in the data field, so one byte layout covers all types.
    always_comb begin
        b0    = sel_type;
        b1    = {2'b00, sel_hdr[7:2]};
        b2    = {sel_hdr[1:0], 2'b00, sel_data[11:8]};
        b3    = sel_data[7:0];
        crc   = dllp_crc16({b3, b2, b1, b0});
        frame = '0;
        frame[0] = WORD_W'({b1, b0, SDP_BYTE1, SDP_BYTE0});
        frame[1] = WORD_W'({crc[7:0], crc[15:8], b3, b2});
    end

    always_comb begin
        unique case (sel_type)
            DLLP_ACK: sent_code = SENT_ACK;
            DLLP_NAK: sent_code = SENT_NAK;
            default:  sent_code = SENT_UFC;
        endcase
    end

    // A request landing on the edge that selects its own type re-arms the flag.
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            ack_pend   <= 1'b0;
            nak_pend   <= 1'b0;
            fcp_pend   <= 1'b0;
            fcnp_pend  <= 1'b0;
            fccpl_pend <= 1'b0;
            seq        <= '0;
        end else if (!link_up) begin
            ack_pend   <= 1'b0;
            nak_pend   <= 1'b0;
            fcp_pend   <= 1'b0;
            fcnp_pend  <= 1'b0;
            fccpl_pend <= 1'b0;
        end else begin
            nak_pend <= (nak_pend && !sel_nak) || req_nak;
            if (req_nak) begin
                ack_pend <= 1'b0;
            end else if (req_ack) begin
                ack_pend <= !(nak_pend && !sel_nak);
            end else begin
                ack_pend <= ack_pend && !sel_ack;
            end
            if (req_ack || req_nak) begin
                seq <= acknak_seq_num_i;
            end
            fcp_pend   <= (fcp_pend && !sel_fcp) || fc_set;
            fcnp_pend  <= (fcnp_pend && !sel_fcnp) || fc_set;
            fccpl_pend <= (fccpl_pend && !sel_fccpl) || fc_set;
        end
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state        <= S_IDLE;
            sel_type     <= DLLP_ACK;
            sel_hdr      <= '0;
            sel_data     <= '0;
            data_DLLP_o  <= '0;
            DLLP_valid_o <= 1'b0;
            dllp_sent_o  <= SENT_NONE;
        end else begin
            dllp_sent_o <= SENT_NONE;
            if (!link_up) begin
                state        <= S_IDLE;
                DLLP_valid_o <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (pick_valid) begin
                            sel_type <= pick_type;
                            sel_hdr  <= pick_hdr;
                            sel_data <= pick_data;
                            state    <= S_CRC;
                        end
                    end
                    S_CRC: begin
                        data_DLLP_o  <= frame;
                        DLLP_valid_o <= 1'b1;
                        state        <= S_SEND;
                    end
                    S_SEND: begin
                        if (DLLP_ready_i) begin
                            DLLP_valid_o <= 1'b0;
                            dllp_sent_o  <= sent_code;
                            state        <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
